// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions used by both the encoder and reader sides: bit order, hex patterns,
// reader FSM states. The reader's optional error counter is enabled with SEG_READER_ERR_CNT_EN.
package seg7_pkg;

    localparam int SEG_A      = 0;
    localparam int SEG_G      = 6;
    localparam int SEG_DP_BIT = 7;

    // Active-high patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] PAT_0 = 7'h3F;
    localparam logic [6:0] PAT_1 = 7'h06;
    localparam logic [6:0] PAT_2 = 7'h5B;
    localparam logic [6:0] PAT_3 = 7'h4F;
    localparam logic [6:0] PAT_4 = 7'h66;
    localparam logic [6:0] PAT_5 = 7'h6D;
    localparam logic [6:0] PAT_6 = 7'h7D;
    localparam logic [6:0] PAT_7 = 7'h07;
    localparam logic [6:0] PAT_8 = 7'h7F;
    localparam logic [6:0] PAT_9 = 7'h6F;
    localparam logic [6:0] PAT_A = 7'h77;
    localparam logic [6:0] PAT_B = 7'h7C;
    localparam logic [6:0] PAT_C = 7'h39;
    localparam logic [6:0] PAT_D = 7'h5E;
    localparam logic [6:0] PAT_E = 7'h79;
    localparam logic [6:0] PAT_F = 7'h71;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } rd_state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] pat;
        case (value)
            4'h0: pat = PAT_0;
            4'h1: pat = PAT_1;
            4'h2: pat = PAT_2;
            4'h3: pat = PAT_3;
            4'h4: pat = PAT_4;
            4'h5: pat = PAT_5;
            4'h6: pat = PAT_6;
            4'h7: pat = PAT_7;
            4'h8: pat = PAT_8;
            4'h9: pat = PAT_9;
            4'hA: pat = PAT_A;
            4'hB: pat = PAT_B;
            4'hC: pat = PAT_C;
            4'hD: pat = PAT_D;
            4'hE: pat = PAT_E;
            default: pat = PAT_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the shared hex table: 7-bit segment pattern -> {valid, value}.
// Built from hex_to_seg so the encoder and decoder can never disagree.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic [3:0] value
);

    always_comb begin
        valid = 1'b0;
        value = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (pattern == hex_to_seg(4'(k))) begin
                valid = 1'b1;
                value = 4'(k);
            end
        end
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Receive side of the multiplexed seven-segment bus: settles each strobe/pattern pair, decodes it,
// stores one value per digit and flags complete frames. Define SEG_READER_ERR_CNT_EN to add err_cnt.
module seven_seg_reader
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 5,
    parameter int SETTLE_CYCLES  = 4,
    parameter int SEL_ACTIVE_LOW = 0,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_DIGITS-1:0]   seg_sel,
    input  logic [7:0]            seg_data,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   dp,
    output logic [N_DIGITS-1:0]   digit_valid,
    output logic                  frame_done,
    output logic                  pat_err
`ifdef SEG_READER_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int IN_W  = N_DIGITS + 8;

    logic [N_DIGITS-1:0]   sel_pc;
    logic [7:0]            data_pc;
    logic [IN_W-1:0]       sample;
    logic [IN_W-1:0]       in_q_reg;
    logic [N_DIGITS-1:0]   q_sel;
    logic [7:0]            q_data;
    logic                  changed;
    logic                  new_sel_zero;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  settled;
    rd_state_t             state_reg, state_next;
    logic                  dec_valid;
    logic [3:0]            dec_value;
    logic                  capture_ok;
    logic                  capture_bad;
    logic [N_DIGITS-1:0]   wr_mask;
    logic                  frame_clear;
    logic [4*N_DIGITS-1:0] digits_reg;
    logic [N_DIGITS-1:0]   dp_reg;
    logic [N_DIGITS-1:0]   valid_reg;
    logic                  frame_done_reg;
    logic                  pat_err_reg;

    assign sel_pc       = (SEL_ACTIVE_LOW != 0) ? ~seg_sel  : seg_sel;
    assign data_pc      = (SEG_ACTIVE_LOW != 0) ? ~seg_data : seg_data;
    assign sample       = {sel_pc, data_pc};
    assign q_sel        = in_q_reg[IN_W-1:8];
    assign q_data       = in_q_reg[7:0];
    assign changed      = (sample != in_q_reg);
    assign new_sel_zero = (sel_pc == '0);
    assign settled      = (cnt_reg >= CNT_W'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            in_q_reg <= sample;
            if (changed)
                cnt_reg <= '0;
            else if (cnt_reg != CNT_W'(SETTLE_CYCLES))
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Transitions look at the raw sample so a change is seen on the same edge that registers it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!new_sel_zero)
                    state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (changed)
                    state_next = new_sel_zero ? ST_IDLE : ST_SETTLE;
                else if (settled)
                    state_next = ST_CAPTURE;
            end
            ST_CAPTURE, ST_HOLD: begin
                if (changed)
                    state_next = new_sel_zero ? ST_IDLE : ST_SETTLE;
                else
                    state_next = ST_HOLD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    seg7_pattern_decode u_decode (
        .pattern (q_data[SEG_G:SEG_A]),
        .valid   (dec_valid),
        .value   (dec_value)
    );

    always_comb begin
        capture_ok  = 1'b0;
        capture_bad = 1'b0;
        if (state_reg == ST_CAPTURE) begin
            capture_ok  = $onehot(q_sel) && dec_valid;
            capture_bad = !capture_ok;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_wr
            assign wr_mask[gi] = capture_ok & q_sel[gi];
        end
    endgenerate

    assign frame_clear = &valid_reg;

    // Frame clear is applied before a coincident capture sets its own valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_reg     <= '0;
            dp_reg         <= '0;
            valid_reg      <= '0;
            frame_done_reg <= 1'b0;
            pat_err_reg    <= 1'b0;
        end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (wr_mask[i]) begin
                    digits_reg[4*i +: 4] <= dec_value;
                    dp_reg[i]            <= q_data[SEG_DP_BIT];
                end
            end
            valid_reg      <= (frame_clear ? '0 : valid_reg) | wr_mask;
            frame_done_reg <= frame_clear;
            pat_err_reg    <= capture_bad;
        end
    end

    assign digits      = digits_reg;
    assign dp          = dp_reg;
    assign digit_valid = valid_reg;
    assign frame_done  = frame_done_reg;
    assign pat_err     = pat_err_reg;

`ifdef SEG_READER_ERR_CNT_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_reg <= 8'h00;
        else if (pat_err_reg && err_cnt_reg != 8'hFF)
            err_cnt_reg <= err_cnt_reg + 8'h01;
    end

    assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_seven_seg_reader.sv
// Scoreboard bench for seven_seg_reader: expected capture/error/frame events are queued as each dwell
// is driven and popped as the DUT reports them. Define SEG_READER_ERR_CNT_EN to also exercise err_cnt.
module tb_seven_seg_reader;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   seg_sel = '0;
    logic [7:0]     seg_data = '0;
    logic [4*N-1:0] digits;
    logic [N-1:0]   dp;
    logic [N-1:0]   digit_valid;
    logic           frame_done;
    logic           pat_err;
`ifdef SEG_READER_ERR_CNT_EN
    logic [7:0]     err_cnt;
`endif

    seven_seg_reader #(
        .N_DIGITS       (N),
        .SETTLE_CYCLES  (4),
        .SEL_ACTIVE_LOW (0),
        .SEG_ACTIVE_LOW (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_sel     (seg_sel),
        .seg_data    (seg_data),
        .digits      (digits),
        .dp          (dp),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .pat_err     (pat_err)
`ifdef SEG_READER_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_CAP = 2'd0, EV_ERR = 2'd1, EV_FRAME = 2'd2} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [2:0] idx;
        logic [3:0] value;
        logic       dpv;
    } ev_t;

    ev_t            sb_q[$];
    int             n_checks = 0;
    int             n_errors = 0;
    logic [N-1:0]   exp_valid = '0;
    logic [4*N-1:0] exp_digits = '0;
    logic [N-1:0]   exp_dp = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_cap(input int idx, input logic [3:0] value, input logic dpv);
        ev_t e;
        e.kind  = EV_CAP;
        e.idx   = 3'(idx);
        e.value = value;
        e.dpv   = dpv;
        sb_q.push_back(e);
        exp_digits[4*idx +: 4] = value;
        exp_dp[idx]            = dpv;
        exp_valid[idx]         = 1'b1;
        if (&exp_valid) begin
            e.kind = EV_FRAME;
            sb_q.push_back(e);
            exp_valid = '0;
        end
    endtask

    task automatic push_err();
        ev_t e;
        e = '0;
        e.kind = EV_ERR;
        sb_q.push_back(e);
    endtask

    // Called at posedge+1; drives a pair and returns at posedge+1 after the dwell.
    task automatic dwell(input logic [N-1:0] sel, input logic [7:0] data, input int cycles);
        seg_sel  = sel;
        seg_data = data;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'h0);
        check({tag, "_dp"}, 32'(dp), 32'h0);
        check({tag, "_valid"}, 32'(digit_valid), 32'h0);
        check({tag, "_frame"}, 32'(frame_done), 32'h0);
        check({tag, "_perr"}, 32'(pat_err), 32'h0);
`ifdef SEG_READER_ERR_CNT_EN
        check({tag, "_errcnt"}, 32'(err_cnt), 32'h0);
`endif
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        exp_valid  = '0;
        exp_digits = '0;
        exp_dp     = '0;
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'h0);
        sb_q.delete();
    endtask

    // Pair already applied; verifies the capture lands exactly 5 edges after the first sampling edge.
    task automatic check_latency(input string tag, input int idx);
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_before"}, 32'(digit_valid[idx]), 32'h0);
        @(posedge clk);
        #1;
        check({tag, "_at"}, 32'(digit_valid[idx]), 32'h1);
    endtask

    ev_t          mon_ev;
    logic [N-1:0] mon_rise;
    logic [N-1:0] prev_valid = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = '0;
        end else begin
            if (frame_done) begin
                $display("event frame_done t=%0t", $time);
                if (sb_q.size() == 0) check("frame_unexpected", 32'h1, 32'h0);
                else begin
                    mon_ev = sb_q.pop_front();
                    check("frame_kind", 32'(mon_ev.kind), 32'(EV_FRAME));
                    check("frame_valid_clear", 32'(digit_valid), 32'h0);
                end
            end
            if (pat_err) begin
                $display("event pat_err t=%0t", $time);
                if (sb_q.size() == 0) check("perr_unexpected", 32'h1, 32'h0);
                else begin
                    mon_ev = sb_q.pop_front();
                    check("perr_kind", 32'(mon_ev.kind), 32'(EV_ERR));
                end
            end
            mon_rise = digit_valid & ~(frame_done ? '0 : prev_valid);
            if (mon_rise != '0) begin
                $display("event capture rise=%b digits=%05h dp=%b t=%0t", mon_rise, digits, dp, $time);
                if (sb_q.size() == 0) check("cap_unexpected", 32'h1, 32'h0);
                else begin
                    mon_ev = sb_q.pop_front();
                    check("cap_kind", 32'(mon_ev.kind), 32'(EV_CAP));
                    check("cap_sel", 32'(mon_rise), 32'h1 << mon_ev.idx);
                    check("cap_value", 32'(digits[4*mon_ev.idx +: 4]), 32'(mon_ev.value));
                    check("cap_dp", 32'(dp[mon_ev.idx]), 32'(mon_ev.dpv));
                end
            end
            prev_valid = digit_valid;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst_n = 1'b1;

        // 1: single digit, latency and single capture over a long dwell
        push_cap(0, 4'h0, 1'b0);
        seg_sel  = 5'b00001;
        seg_data = 8'h3F;
        check_latency("t1_lat", 0);
        dwell(5'b00001, 8'h3F, 4);
        check("t1_valid", 32'(digit_valid), 32'h01);
        check("t1_digit0", 32'(digits[3:0]), 32'h0);
        do_reset("t1_rst");

        // 2: full frame, one digit per dwell
        push_cap(0, 4'h7, 1'b0); dwell(5'b00001, 8'h07, 6);
        push_cap(1, 4'h6, 1'b0); dwell(5'b00010, 8'h7D, 6);
        push_cap(2, 4'h7, 1'b0); dwell(5'b00100, 8'h07, 6);
        push_cap(3, 4'h4, 1'b1); dwell(5'b01000, 8'hE6, 6);
        push_cap(4, 4'h3, 1'b0); dwell(5'b10000, 8'h4F, 6);
        dwell(5'b00000, 8'h00, 3);
        check("t2_digits", 32'(digits), 32'h34767);
        check("t2_dp", 32'(dp), 32'(exp_dp));
        check("t2_valid", 32'(digit_valid), 32'h0);

        // 3: unstable pattern never captures, then a stable one does
        for (int k = 0; k < 4; k++)
            dwell(5'b00010, (k % 2 == 0) ? 8'h06 : 8'h5B, 2);
        check("t3_no_capture", 32'(digit_valid), 32'h0);
        push_cap(1, 4'h2, 1'b0);
        dwell(5'b00010, 8'h5B, 8);
        check("t3_digits", 32'(digits), 32'(exp_digits));

        // 4: undecodable pattern, then a non-one-hot strobe
        push_err(); dwell(5'b00100, 8'h55, 8);
        push_err(); dwell(5'b00011, 8'h3F, 8);
        check("t4_digits", 32'(digits), 32'(exp_digits));
        check("t4_valid", 32'(digit_valid), 32'h02);

        // 5: reset mid-settle clears immediately, capture needs a full new settle
        dwell(5'b00000, 8'h00, 2);
        dwell(5'b00001, 8'h6D, 2);
        do_reset("t5_rst");
        push_cap(0, 4'h5, 1'b0);
        check_latency("t5_lat", 0);
        check("t5_digits", 32'(digits), 32'h00005);

`ifdef SEG_READER_ERR_CNT_EN
        // 6: error counter saturates and clears only on reset
        do_reset("t6_rst0");
        for (int k = 0; k < 300; k++) begin
            push_err();
            dwell(5'b00100, (k % 2 == 0) ? 8'h55 : 8'h56, 7);
        end
        dwell(5'b00000, 8'h00, 2);
        check("t6_errcnt_sat", 32'(err_cnt), 32'hFF);
        do_reset("t6_rst1");
`endif

        dwell(5'b00000, 8'h00, 4);
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
